// File: rtl/fifo_arb_pkg.sv
// Shared types and the reference round-robin search for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic [0:0] {IDLE, GRANT} arb_state_t;

  localparam int STAT_W  = 16;
  localparam int MAX_REQ = 16;

  // Reference model of the arbitration rule: first valid index strictly after `last`,
  // wrapping modulo num_req. Returns `last` when nothing is valid.
  function automatic int rr_next(input int num_req, input int last,
                                 input logic [MAX_REQ-1:0] valid_vec);
    int pick;
    int idx;
    pick = last;
    // Walk from farthest to nearest so the nearest valid index wins.
    for (int k = MAX_REQ; k >= 1; k--) begin
      if (k <= num_req) begin
        idx = (last + k) % num_req;
        if (valid_vec[idx]) pick = idx;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: next valid requester after the last owner.
module rr_picker import fifo_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_vec,
  input  logic [IDW-1:0]     last,
  output logic [IDW-1:0]     pick,
  output logic               any_valid
);

  logic [MAX_REQ-1:0] valid_ext;

  always_comb begin
    valid_ext                = '0;
    valid_ext[NUM_REQ-1:0]   = valid_vec;
    pick                     = IDW'(rr_next(NUM_REQ, int'(last), valid_ext));
    any_valid                = |valid_vec;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Define FIFO_WR_ARB_STATS_EN to add per-requester saturating beat counters (stat_beats).
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic                            fifo_full,
  output logic                            fifo_wr_en,
  output logic [DATA_WIDTH-1:0]           fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]       stat_beats
`endif
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int BW  = $clog2(MAX_BURST + 1);
  localparam logic [BW-1:0] LastBeat = BW'(MAX_BURST - 1);

  arb_state_t      state_q, state_d;
  logic [IDW-1:0]  owner_q, owner_d;
  logic [IDW-1:0]  last_q, last_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]        pick;
  logic                  any_valid;
  logic                  granted;
  logic                  owner_valid;
  logic                  xfer;
  logic [DATA_WIDTH-1:0] owner_lane;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_rr_picker (
    .valid_vec (req_valid),
    .last      (last_q),
    .pick      (pick),
    .any_valid (any_valid)
  );

  // Handshake and FIFO-side outputs; ready/write are forced low while reset is held.
  always_comb begin
    granted      = (state_q == GRANT);
    owner_valid  = req_valid[owner_q];
    owner_lane   = req_data[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH];
    xfer         = granted && owner_valid && !fifo_full && !reset;
    req_ready    = '0;
    if (granted && !fifo_full && !reset) req_ready[owner_q] = 1'b1;
    fifo_wr_en   = xfer;
    fifo_data_in = granted ? owner_lane : '0;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    beat_cnt_d = beat_cnt_q;
    if (reset) begin
      state_d    = IDLE;
      owner_d    = '0;
      last_d     = IDW'(NUM_REQ - 1);
      beat_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            owner_d    = pick;
            beat_cnt_d = '0;
            state_d    = GRANT;
          end
        end
        GRANT: begin
          // A dropped valid ends the burst even while the FIFO is full.
          if (!owner_valid) begin
            state_d = IDLE;
            last_d  = owner_q;
          end else if (xfer) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
            if (beat_cnt_q == LastBeat) begin
              state_d = IDLE;
              last_d  = owner_q;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q    <= state_d;
    owner_q    <= owner_d;
    last_q     <= last_d;
    beat_cnt_q <= beat_cnt_d;
  end

  assign grant_id = owner_q;
  assign busy     = (state_q == GRANT);

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  logic [STAT_W-1:0] stat_d [NUM_REQ];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      stat_d[i] = stat_q[i];
      if (reset) begin
        stat_d[i] = '0;
      end else if (xfer && (owner_q == IDW'(i)) && (stat_q[i] != '1)) begin
        stat_d[i] = stat_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    stat_q <= stat_d;
  end

  always_comb begin
    stat_beats = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_beats[i*STAT_W +: STAT_W] = stat_q[i];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: constant vector table, directed corner sequences and a
// randomized run against a cycle-level behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*16-1:0] stat_beats;
`endif

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .grant_id     (grant_id),
    .busy         (busy)
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    .stat_beats   (stat_beats)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural model: who owns the port, how many beats they have moved, stats.
  bit m_busy;
  int m_owner, m_last, m_beats;
  int m_stats [N];

  // Producer side: each lane presents base+sent, advancing on its own handshake.
  int sent [N];
  int base [N];

  logic [7:0] wlog [$];
  logic [N-1:0] s_ready;
  logic s_wr, s_busy;
  logic [7:0] s_data;
  logic [1:0] s_gid;

  typedef struct {
    bit         rst;
    logic [3:0] valid;
    bit         full;
    logic [3:0] ready;
    bit         wr;
    logic [7:0] data;
    logic [1:0] gid;
    bit         busy;
  } vec_t;
  vec_t tbl [12];

  function automatic logic [7:0] lane_val(int r);
    return 8'(base[r] + sent[r]);
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_last  = N - 1;
    m_owner = 0;
    m_beats = 0;
    for (int r = 0; r < N; r++) m_stats[r] = 0;
  endtask

  task automatic step(input bit rst, input logic [N-1:0] valid, input bit full);
    logic [N-1:0] e_ready;
    bit           e_wr;
    logic [7:0]   e_data;
    @(negedge clk);
    reset     = rst;
    req_valid = valid;
    fifo_full = full;
    for (int r = 0; r < N; r++) req_data[r*DW +: DW] = lane_val(r);
    #1;
    e_ready = '0;
    e_wr    = 1'b0;
    e_data  = 8'h00;
    if (m_busy) e_data = lane_val(m_owner);
    if (m_busy && !full && !rst) begin
      e_ready[m_owner] = 1'b1;
      e_wr             = valid[m_owner];
    end
    s_ready = req_ready;
    s_wr    = fifo_wr_en;
    s_data  = fifo_data_in;
    s_gid   = grant_id;
    s_busy  = busy;
    chk("req_ready", 32'(req_ready), 32'(e_ready));
    chk("fifo_wr_en", 32'(fifo_wr_en), 32'(e_wr));
    chk("fifo_data_in", 32'(fifo_data_in), 32'(e_data));
    chk("grant_id", 32'(grant_id), 32'(m_owner));
    chk("busy", 32'(busy), 32'(m_busy));
`ifdef FIFO_WR_ARB_STATS_EN
    for (int r = 0; r < N; r++) chk("stat_beats", 32'(stat_beats[r*16 +: 16]), 32'(m_stats[r]));
`endif
    if (fifo_wr_en === 1'b1) wlog.push_back(fifo_data_in);
    @(posedge clk);
    for (int r = 0; r < N; r++) if (valid[r] && s_ready[r] === 1'b1) sent[r]++;
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (valid != '0) begin
        for (int k = 1; k <= N; k++) begin
          if (valid[(m_last + k) % N]) begin
            m_owner = (m_last + k) % N;
            break;
          end
        end
        m_busy  = 1'b1;
        m_beats = 0;
      end
    end else if (!valid[m_owner]) begin
      m_busy = 1'b0;
      m_last = m_owner;
    end else if (e_wr) begin
      m_beats++;
      if (m_stats[m_owner] < 65535) m_stats[m_owner]++;
      if (m_beats == MB) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end
    end
  endtask

  task automatic do_reset();
    for (int r = 0; r < N; r++) begin
      sent[r] = 0;
      base[r] = r * 16;
    end
    step(1'b1, '0, 1'b0);
    step(1'b0, '0, 1'b0);
    wlog.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] gq [$];
    bit         prev_busy;
    logic [3:0] rvalid;

    tbl[0]  = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h10, 2'd0, 1'b1};
    tbl[3]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h11, 2'd0, 1'b1};
    tbl[4]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h12, 2'd0, 1'b1};
    tbl[5]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h13, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 4'b0001, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};
    tbl[7]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h14, 2'd0, 1'b1};
    tbl[8]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h15, 2'd0, 1'b1};
    tbl[9]  = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h16, 2'd0, 1'b1};
    tbl[10] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 1'b1, 8'h17, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 1'b0, 8'h00, 2'd0, 1'b0};

    reset     = 1'b1;
    req_valid = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    for (int r = 0; r < N; r++) begin
      sent[r] = 0;
      base[r] = r * 16;
    end
    repeat (2) @(posedge clk);
    model_reset();

    // Single requester streaming 0x10..0x17 with a one-cycle bubble between bursts.
    base[0] = 8'h10;
    wlog.delete();
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].rst, tbl[i].valid, tbl[i].full);
      chk("tbl_ready", 32'(s_ready), 32'(tbl[i].ready));
      chk("tbl_wr_en", 32'(s_wr), 32'(tbl[i].wr));
      chk("tbl_data", 32'(s_data), 32'(tbl[i].data));
      chk("tbl_grant_id", 32'(s_gid), 32'(tbl[i].gid));
      chk("tbl_busy", 32'(s_busy), 32'(tbl[i].busy));
    end
    chk("stream_count", 32'(wlog.size()), 32'd8);
    for (int i = 0; i < wlog.size() && i < 8; i++) chk("stream_data", 32'(wlog[i]), 32'(8'h10 + i));

    // All requesters valid: order 0,1,2,3,0 in blocks of four beats.
    do_reset();
    prev_busy = 1'b0;
    for (int c = 0; c < 40 && wlog.size() < 20; c++) begin
      step(1'b0, 4'b1111, 1'b0);
      if (s_busy && !prev_busy) gq.push_back(s_gid);
      prev_busy = s_busy;
    end
    chk("rr_count", 32'(wlog.size()), 32'd20);
    for (int i = 0; i < wlog.size() && i < 20; i++)
      chk("rr_data", 32'(wlog[i]), 32'(((i / 4) % 4) * 16 + ((i / 4) / 4) * 4 + i % 4));
    chk("rr_bursts", 32'(gq.size()), 32'd5);
    for (int i = 0; i < gq.size() && i < 5; i++) chk("rr_order", 32'(gq[i]), 32'(i % 4));

    // FIFO full for three cycles after two beats of owner 2.
    do_reset();
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'b0100, 1'b1);
      chk("stall_ready", 32'(s_ready), 32'd0);
      chk("stall_wr_en", 32'(s_wr), 32'd0);
      chk("stall_busy", 32'(s_busy), 32'd1);
    end
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0100, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("stall_busy_end", 32'(s_busy), 32'd0);
    chk("stall_count", 32'(wlog.size()), 32'd4);
    for (int i = 0; i < wlog.size() && i < 4; i++) chk("stall_data", 32'(wlog[i]), 32'(8'h20 + i));

    // Owner 1 drops valid after two beats; requester 3 takes over after one IDLE cycle.
    do_reset();
    step(1'b0, 4'b1010, 1'b0);
    step(1'b0, 4'b1010, 1'b0);
    chk("drop_gid0", 32'(s_gid), 32'd1);
    step(1'b0, 4'b1010, 1'b0);
    step(1'b0, 4'b1000, 1'b0);
    chk("drop_busy", 32'(s_busy), 32'd1);
    chk("drop_wr_en", 32'(s_wr), 32'd0);
    step(1'b0, 4'b1000, 1'b0);
    chk("drop_idle", 32'(s_busy), 32'd0);
    chk("drop_gid_hold", 32'(s_gid), 32'd1);
    step(1'b0, 4'b1000, 1'b0);
    chk("drop_next_busy", 32'(s_busy), 32'd1);
    chk("drop_next_gid", 32'(s_gid), 32'd3);

    // Reset on the third beat abandons the burst; requester 0 wins afterwards.
    do_reset();
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b0, 4'b0001, 1'b0);
    step(1'b1, 4'b0001, 1'b0);
    chk("rst_ready_gate", 32'(s_ready), 32'd0);
    chk("rst_wr_gate", 32'(s_wr), 32'd0);
    step(1'b0, 4'b1001, 1'b0);
    chk("rst_busy", 32'(s_busy), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    step(1'b0, 4'b1001, 1'b0);
    chk("rst_first_gid", 32'(s_gid), 32'd0);
    chk("rst_first_busy", 32'(s_busy), 32'd1);

    // Randomized traffic, back-pressure and occasional reset against the model.
    do_reset();
    rvalid = 4'($urandom_range(0, 15));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) rvalid = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 99) == 0), rvalid, ($urandom_range(0, 3) == 0));
    end

`ifdef FIFO_WR_ARB_STATS_EN
    do_reset();
    for (int c = 0; c < 200 && sent[1] < 40; c++) step(1'b0, 4'b0010, 1'b0);
    for (int c = 0; c < 50 && sent[3] < 7; c++) step(1'b0, 4'b1000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("stat_lane0", 32'(stat_beats[0 +: 16]), 32'd0);
    chk("stat_lane1", 32'(stat_beats[16 +: 16]), 32'd40);
    chk("stat_lane2", 32'(stat_beats[32 +: 16]), 32'd0);
    chk("stat_lane3", 32'(stat_beats[48 +: 16]), 32'd7);
    step(1'b1, 4'b0000, 1'b0);
    step(1'b0, 4'b0000, 1'b0);
    chk("stat_clear", 32'(stat_beats), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Shares one synchronous_fifo write port between NUM_REQ producers.
- Each producer uses a valid/ready handshake. The arbiter grants one owner at a time using round-robin, for a burst of up to MAX_BURST beats.
- It drives the FIFO wr_en/data_in directly and stalls on FIFO full.
- Sits between the producer blocks and the FIFO instance; the FIFO read side is untouched.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- DATA_WIDTH, 8, beat width; must equal the FIFO DATA_WIDTH.
- MAX_BURST, 4, maximum beats per grant (1..256).

Ports:
- clk  input  1  clock, all state updates on posedge.
- reset  input  1  synchronous, active-high.
- req_valid  input  NUM_REQ  per-requester beat valid.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened beats; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  DATA_WIDTH  FIFO write data.
- grant_id  output  $clog2(NUM_REQ)  current/last owner index.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset values:
  - state=IDLE, last_owner=NUM_REQ-1 (so the first pick is requester 0).
  - owner=0, beat_cnt=0.
  - grant_id=0, busy=0, req_ready=0, fifo_wr_en=0, fifo_data_in=0.
- req_ready and fifo_wr_en are gated low combinationally while reset is high.
- States: IDLE, GRANT.
- IDLE:
  - If any req_valid bit is set, pick the first valid index searching upward from last_owner+1 modulo NUM_REQ.
  - owner <= pick, beat_cnt <= 0, go to GRANT.
  - Arbitration costs exactly one cycle; no beat is accepted in IDLE.
- GRANT:
  - req_ready[owner] = !fifo_full; all other ready bits are 0.
  - Transfer when req_valid[owner] && req_ready[owner]. In a transfer cycle, fifo_wr_en=1 and fifo_data_in=req_data[owner] in the same cycle (zero added latency).
  - fifo_data_in holds the owner's lane whenever in GRANT, and 0 in IDLE.
  - Each transfer increments beat_cnt.
- Burst end (transition to IDLE, last_owner <= owner):
  - (a) a transfer occurs with beat_cnt==MAX_BURST-1; or
  - (b) req_valid[owner]==0 in any GRANT cycle, including while fifo_full.
- fifo_full in GRANT:
  - Stall: no transfer, beat_cnt holds, state holds (unless (b) applies).
  - The full flag is registered-derived in the FIFO, so a write in cycle N is reflected in full at N+1. The arbiter relies on that flag only; it keeps no shadow count.
- Round-robin is fair: a continuously requesting index waits at most NUM_REQ-1 bursts.
- Single requester: a back-to-back burst yields a one-cycle IDLE bubble between bursts.
- grant_id = owner; it retains its value in IDLE. busy = (state==GRANT).
- Reset mid-burst: next state IDLE; the partial burst is abandoned; beats already written stay in the FIFO.
- req_valid on non-owners is ignored during GRANT; their data need not be stable.
- beat_cnt width is $clog2(MAX_BURST+1); no wrap inside a burst.

Optional Feature:
- Macro: FIFO_WR_ARB_STATS_EN.
- With the macro:
  - Adds output stat_beats, NUM_REQ*16 bits: per-requester count of accepted beats.
  - Counters saturate at 16'hFFFF, clear on reset, and increment in the transfer cycle (visible next cycle).
- Without the macro:
  - The port and counters are absent.
  - All other behaviour is identical.

Decomposition:
- Package fifo_arb_pkg:
  - arb_state_t enum {IDLE, GRANT}.
  - Constant STAT_W=16.
  - Function rr_next(last, valid_vec) documented as the reference model.
- Sub-module rr_picker:
  - Combinational round-robin search.
  - Inputs: valid vector, last index.
  - Outputs: pick index, any_valid.
  - Instantiated once.
- Top level holds the FSM, beat_cnt, the lane mux and the optional stats.

Test Plan:
- Reset, then req_valid=4'b0001 streaming 0x10..0x17, FIFO empty:
  - grant_id=0 after 1 IDLE cycle.
  - Beats 0x10..0x13 are written on consecutive cycles, then 1-cycle bubble, then 0x14..0x17.
- req_valid=4'b1111, every requester always valid:
  - Grant order is 0,1,2,3,0; each burst is exactly 4 fifo_wr_en pulses.
  - FIFO contents are grouped in blocks of 4 per requester.
- fifo_full asserted for 3 cycles mid-burst (owner 2, beat 2):
  - req_ready=0 and fifo_wr_en=0 for 3 cycles; beat_cnt holds.
  - The burst completes with beats 3-4 afterwards; no data loss or duplication against the scoreboard.
- Owner 1 drops req_valid after 2 beats while requester 3 is valid:
  - Burst ends, last_owner=1.
  - Next grant is 3 after 1 IDLE cycle.
- Reset asserted on beat 3 of a burst:
  - Next cycle busy=0, req_ready=0.
  - After reset, the first grant goes to requester 0 (lowest valid).
- With FIFO_WR_ARB_STATS_EN: 40 beats from requester 1, 7 from requester 3:
  - stat_beats lanes read 40 and 7; other lanes read 0.
  - Reset clears all lanes.
